// File: rtl/harry_jump_ctrl.sv
// ---------------------------------------------------------------------------
// harry_jump_ctrl
//
// Frame-rate motion sequencer for Harry. Once per video frame it decides
// whether Harry stands, runs, jumps (rise / apex hold / fall), drops into a
// pit, dies and respawns, or leaves the level through the right edge. It owns
// Harry's X/Y position and publishes the new_level pulse.
//
// Configuration macro:
//   HARRY_AIR_CONTROL_EN - when defined, A/D steer Harry on every airborne
//                          frame. When undefined, the horizontal speed taken
//                          at takeoff is kept for the whole jump.
//
// Ports:
//   frame_clk   in   1  frame clock, one rising edge per video frame
//   Reset       in   1  synchronous active-high reset
//   keycode     in   8  USB keycode: 04 left (A), 07 right (D), 2C jump (space)
//   harry_death in   1  death request from collision logic, level-sampled
//   pit_below   in   1  no ground under Harry's current X
//   HarryX      out 10  sprite left X
//   HarryY      out 10  sprite top Y
//   HarryS_X    out 10  sprite width (constant)
//   HarryS_Y    out 10  sprite height (constant)
//   new_level   out  1  high for the single frame in which Harry exits right
//   airborne    out  1  high in JUMP_UP, APEX and FALL
//   respawning  out  1  high in DEAD
//   state       out  3  FSM state code for debug / sprite select
// ---------------------------------------------------------------------------
module harry_jump_ctrl #(
    parameter int X_START     = 20,
    parameter int Y_GROUND    = 280,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int SIZE_X      = 16,
    parameter int SIZE_Y      = 32,
    parameter int JUMP_V0     = 8,
    parameter int MAX_FALL    = 8,
    parameter int GRAVITY_DIV = 2,
    parameter int APEX_HOLD   = 4,
    parameter int RESPAWN_FR  = 60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       harry_death,
    input  logic       pit_below,
    output logic [9:0] HarryX,
    output logic [9:0] HarryY,
    output logic [9:0] HarryS_X,
    output logic [9:0] HarryS_Y,
    output logic       new_level,
    output logic       airborne,
    output logic       respawning,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        JUMP_UP = 3'd2,
        APEX    = 3'd3,
        FALL    = 3'd4,
        LAND    = 3'd5,
        DEAD    = 3'd6
    } state_t;

    // Parameters resized once so every compare below is same-width.
    localparam logic [9:0]         X_START_P  = 10'(X_START);
    localparam logic [9:0]         Y_GROUND_P = 10'(Y_GROUND);
    localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] Y_GROUND_S = 11'(Y_GROUND);
    localparam logic signed [10:0] Y_MAX_S    = 11'(Y_MAX);
    localparam logic signed [10:0] SIZE_Y_S   = 11'(SIZE_Y);
    localparam logic [10:0]        X_MAX_U    = 11'(X_MAX);
    localparam logic [10:0]        SIZE_X_U   = 11'(SIZE_X);
    localparam logic signed [5:0]  JUMP_VY    = 6'(-JUMP_V0);
    localparam logic signed [5:0]  MAX_FALL_V = 6'(MAX_FALL);
    localparam logic [3:0]         GRAV_LAST  = 4'(GRAVITY_DIV - 1);
    localparam logic [5:0]         APEX_LAST  = 6'(APEX_HOLD - 1);
    localparam logic [5:0]         DEAD_LAST  = 6'(RESPAWN_FR - 1);

    state_t              state_q, state_n;
    logic [9:0]          x_q, x_n, y_q, y_n;
    logic signed [1:0]   vx_q, vx_n;
    logic signed [5:0]   vy_q, vy_n;
    logic [3:0]          grav_q, grav_n;
    logic [5:0]          cnt_q, cnt_n;
    logic                space_q;

    logic                key_left, key_right, key_space, space_rise;
    logic signed [1:0]   key_vx, vx_air, vx_use;
    logic signed [10:0]  x_sum, y_sum, y_bottom;
    logic [10:0]         x_right;
    logic [9:0]          x_step;
    logic signed [5:0]   vy_grav;
    logic [3:0]          grav_step;
    logic                death_req, exit_req;

    // Negative intermediate results pin to zero; anything else already fits.
    function automatic logic [9:0] clamp10(input logic signed [10:0] v);
        if (v < 11'sd0)
            return 10'd0;
        return v[9:0];
    endfunction

    // Keyboard decode. A jump only starts on the frame space goes down, so
    // holding space never produces a second jump.
    always_comb begin
        key_left   = (keycode == 8'h04);
        key_right  = (keycode == 8'h07);
        key_space  = (keycode == 8'h2C);
        space_rise = key_space && !space_q;
        if (key_right)
            key_vx = 2'sd1;
        else if (key_left)
            key_vx = 2'b11;
        else
            key_vx = 2'sd0;
    end

    // Shared position and gravity arithmetic, done in 11 signed bits so that
    // stepping past the left edge or the ceiling is visible as a negative.
    always_comb begin
`ifdef HARRY_AIR_CONTROL_EN
        vx_air = key_vx;
`else
        vx_air = vx_q;
`endif
        vx_use   = (state_q == IDLE || state_q == RUN) ? key_vx : vx_air;
        x_sum    = $signed({1'b0, x_q}) + $signed({{9{vx_use[1]}}, vx_use});
        x_step   = (x_sum < X_MIN_S) ? X_MIN_S[9:0] : clamp10(x_sum);
        y_sum    = $signed({1'b0, y_q}) + $signed({{5{vy_q[5]}}, vy_q});
        y_bottom = y_sum + SIZE_Y_S;
        x_right  = {1'b0, x_q} + SIZE_X_U;
        if (grav_q == GRAV_LAST) begin
            vy_grav   = vy_q + 6'sd1;
            grav_step = 4'd0;
        end else begin
            vy_grav   = vy_q;
            grav_step = grav_q + 4'd1;
        end
    end

    // Frame-level overrides: a death request beats a level exit, and neither
    // applies while Harry is already dead.
    always_comb begin
        death_req = harry_death && (state_q != DEAD);
        exit_req  = (x_right >= X_MAX_U) && !death_req && (state_q != DEAD);
    end

    // State register together with the position / velocity datapath.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= IDLE;
            x_q     <= X_START_P;
            y_q     <= Y_GROUND_P;
            vx_q    <= 2'sd0;
            vy_q    <= 6'sd0;
            grav_q  <= 4'd0;
            cnt_q   <= 6'd0;
            space_q <= 1'b0;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            vx_q    <= vx_n;
            vy_q    <= vy_n;
            grav_q  <= grav_n;
            cnt_q   <= cnt_n;
            space_q <= key_space;
        end
    end

    // Next-state logic. cnt_q times both the apex hold and the dead period,
    // and is cleared on entry to either state.
    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        vx_n    = vx_q;
        vy_n    = vy_q;
        grav_n  = grav_q;
        cnt_n   = cnt_q;
        if (death_req) begin
            state_n = DEAD;
            vx_n    = 2'sd0;
            vy_n    = 6'sd0;
            grav_n  = 4'd0;
            cnt_n   = 6'd0;
        end else if (exit_req) begin
            state_n = IDLE;
            x_n     = X_START_P;
            y_n     = Y_GROUND_P;
            vx_n    = 2'sd0;
            vy_n    = 6'sd0;
            grav_n  = 4'd0;
            cnt_n   = 6'd0;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    x_n  = x_step;
                    vx_n = key_vx;
                    if (pit_below) begin
                        state_n = FALL;
                        vy_n    = 6'sd1;
                        grav_n  = 4'd0;
                    end else if (space_rise) begin
                        state_n = JUMP_UP;
                        vy_n    = JUMP_VY;
                        grav_n  = 4'd0;
                    end else if (key_vx != 2'sd0) begin
                        state_n = RUN;
                    end else begin
                        state_n = IDLE;
                    end
                end
                JUMP_UP: begin
                    x_n  = x_step;
                    vx_n = vx_air;
                    if (y_sum < 11'sd0) begin
                        y_n     = 10'd0;
                        vy_n    = 6'sd0;
                        grav_n  = 4'd0;
                        cnt_n   = 6'd0;
                        state_n = APEX;
                    end else begin
                        y_n    = clamp10(y_sum);
                        vy_n   = vy_grav;
                        grav_n = grav_step;
                        if (vy_grav == 6'sd0) begin
                            cnt_n   = 6'd0;
                            state_n = APEX;
                        end
                    end
                end
                APEX: begin
                    x_n  = x_step;
                    vx_n = vx_air;
                    if (cnt_q == APEX_LAST) begin
                        state_n = FALL;
                        vy_n    = 6'sd1;
                        grav_n  = 4'd0;
                        cnt_n   = 6'd0;
                    end else begin
                        cnt_n = cnt_q + 6'd1;
                    end
                end
                FALL: begin
                    x_n    = x_step;
                    vx_n   = vx_air;
                    grav_n = grav_step;
                    vy_n   = (vy_grav > MAX_FALL_V) ? MAX_FALL_V : vy_grav;
                    if (y_sum >= Y_GROUND_S && !pit_below) begin
                        y_n     = Y_GROUND_P;
                        vy_n    = 6'sd0;
                        grav_n  = 4'd0;
                        state_n = LAND;
                    end else if (y_bottom >= Y_MAX_S) begin
                        y_n     = clamp10(y_sum);
                        vy_n    = 6'sd0;
                        grav_n  = 4'd0;
                        cnt_n   = 6'd0;
                        state_n = DEAD;
                    end else begin
                        y_n = clamp10(y_sum);
                    end
                end
                LAND: begin
                    vx_n    = 2'sd0;
                    state_n = (key_vx != 2'sd0) ? RUN : IDLE;
                end
                DEAD: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_n = IDLE;
                        x_n     = X_START_P;
                        y_n     = Y_GROUND_P;
                        cnt_n   = 6'd0;
                    end else begin
                        cnt_n = cnt_q + 6'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs. new_level is taken straight from the exit decision so it lines
    // up with the frame that shows Harry at the right edge and vanishes if
    // death or reset wins that frame.
    always_comb begin
        HarryX     = x_q;
        HarryY     = y_q;
        HarryS_X   = 10'(SIZE_X);
        HarryS_Y   = 10'(SIZE_Y);
        state      = state_q;
        airborne   = (state_q == JUMP_UP) || (state_q == APEX) || (state_q == FALL);
        respawning = (state_q == DEAD);
        new_level  = exit_req && !Reset;
    end

endmodule

// File: tb/tb_harry_jump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_harry_jump_ctrl
//
// Directed testbench for harry_jump_ctrl. Each scenario task drives the
// keyboard / collision inputs frame by frame and compares the outputs with
// hand-worked values for the default parameter set.
// ---------------------------------------------------------------------------
module tb_harry_jump_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       harry_death;
    logic       pit_below;
    logic [9:0] HarryX, HarryY, HarryS_X, HarryS_Y;
    logic       new_level, airborne, respawning;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    harry_jump_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .harry_death (harry_death),
        .pit_below   (pit_below),
        .HarryX      (HarryX),
        .HarryY      (HarryY),
        .HarryS_X    (HarryS_X),
        .HarryS_Y    (HarryS_Y),
        .new_level   (new_level),
        .airborne    (airborne),
        .respawning  (respawning),
        .state       (state)
    );

    // Free-running frame clock.
    always #5 frame_clk = ~frame_clk;

    // Safety net in case a scenario stops making progress.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance n frames; outputs are read 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; keycode = 8'h00; harry_death = 1'b0; pit_below = 1'b0;
        step(2);
        Reset = 1'b0;
    endtask

    // Reset then five idle frames: Harry parked at the spawn point.
    task automatic test_reset();
        do_reset();
        step(5);
        n_cmp++; if (HarryX !== 10'd20) begin n_bad++; $display("[TB] FAIL reset_x: got %0d expected 20", HarryX); end
        n_cmp++; if (HarryY !== 10'd280) begin n_bad++; $display("[TB] FAIL reset_y: got %0d expected 280", HarryY); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if (new_level !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_new_level: got %b expected 0", new_level); end
        n_cmp++; if (airborne !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_airborne: got %b expected 0", airborne); end
        n_cmp++; if (respawning !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_respawning: got %b expected 0", respawning); end
        n_cmp++; if (HarryS_X !== 10'd16) begin n_bad++; $display("[TB] FAIL size_x: got %0d expected 16", HarryS_X); end
        n_cmp++; if (HarryS_Y !== 10'd32) begin n_bad++; $display("[TB] FAIL size_y: got %0d expected 32", HarryS_Y); end
    endtask

    // Single space tap: 1 takeoff + 16 rise + 4 apex + 16 fall + 1 land = 38 frames.
    task automatic test_jump();
        keycode = 8'h2C;
        step(1);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("[TB] FAIL takeoff_state: got %0d expected 2", state); end
        n_cmp++; if (HarryY !== 10'd280) begin n_bad++; $display("[TB] FAIL takeoff_y: got %0d expected 280", HarryY); end
        n_cmp++; if (airborne !== 1'b1) begin n_bad++; $display("[TB] FAIL takeoff_airborne: got %b expected 1", airborne); end
        keycode = 8'h00;
        step(15);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("[TB] FAIL rise15_state: got %0d expected 2", state); end
        n_cmp++; if (HarryY !== 10'd209) begin n_bad++; $display("[TB] FAIL rise15_y: got %0d expected 209", HarryY); end
        step(1);
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("[TB] FAIL apex_state: got %0d expected 3", state); end
        n_cmp++; if (HarryY !== 10'd208) begin n_bad++; $display("[TB] FAIL apex_y: got %0d expected 208", HarryY); end
        n_cmp++; if (HarryX !== 10'd20) begin n_bad++; $display("[TB] FAIL apex_x: got %0d expected 20", HarryX); end
        step(3);
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("[TB] FAIL apex_hold_state: got %0d expected 3", state); end
        n_cmp++; if (HarryY !== 10'd208) begin n_bad++; $display("[TB] FAIL apex_hold_y: got %0d expected 208", HarryY); end
        step(1);
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("[TB] FAIL fall_entry_state: got %0d expected 4", state); end
        n_cmp++; if (HarryY !== 10'd208) begin n_bad++; $display("[TB] FAIL fall_entry_y: got %0d expected 208", HarryY); end
        step(15);
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("[TB] FAIL fall15_state: got %0d expected 4", state); end
        n_cmp++; if (HarryY !== 10'd272) begin n_bad++; $display("[TB] FAIL fall15_y: got %0d expected 272", HarryY); end
        step(1);
        n_cmp++; if (state !== 3'd5) begin n_bad++; $display("[TB] FAIL land_state: got %0d expected 5", state); end
        n_cmp++; if (HarryY !== 10'd280) begin n_bad++; $display("[TB] FAIL land_y: got %0d expected 280", HarryY); end
        n_cmp++; if (airborne !== 1'b0) begin n_bad++; $display("[TB] FAIL land_airborne: got %b expected 0", airborne); end
        step(1);
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("[TB] FAIL post_land_state: got %0d expected 0", state); end
    endtask

    // Walk right from X=20: the exit frame shows X=623 after 603 frames.
    task automatic test_edge_exit();
        bit found;
        int frames;
        found = 1'b0;
        frames = 0;
        keycode = 8'h07;
        for (int i = 0; i < 700 && !found; i++) begin
            step(1);
            frames++;
            if (new_level === 1'b1) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("[TB] FAIL exit_seen: got %b expected 1", found); end
        n_cmp++; if (frames !== 603) begin n_bad++; $display("[TB] FAIL exit_frames: got %0d expected 603", frames); end
        n_cmp++; if (HarryX !== 10'd623) begin n_bad++; $display("[TB] FAIL exit_x: got %0d expected 623", HarryX); end
        step(1);
        n_cmp++; if (new_level !== 1'b0) begin n_bad++; $display("[TB] FAIL exit_pulse_width: got %b expected 0", new_level); end
        n_cmp++; if (HarryX !== 10'd20) begin n_bad++; $display("[TB] FAIL exit_respawn_x: got %0d expected 20", HarryX); end
        n_cmp++; if (HarryY !== 10'd280) begin n_bad++; $display("[TB] FAIL exit_respawn_y: got %0d expected 280", HarryY); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("[TB] FAIL exit_state: got %0d expected 0", state); end
        step(1);
        n_cmp++; if (HarryX !== 10'd21) begin n_bad++; $display("[TB] FAIL exit_resume_x: got %0d expected 21", HarryX); end
        keycode = 8'h00;
        step(1);
    endtask

    // Death arriving on the exit frame suppresses the pulse and the exit.
    task automatic test_exit_death();
        keycode = 8'h07;
        for (int i = 0; i < 700 && HarryX !== 10'd622; i++) step(1);
        n_cmp++; if (HarryX !== 10'd622) begin n_bad++; $display("[TB] FAIL xd_reach: got %0d expected 622", HarryX); end
        step(1);
        n_cmp++; if (new_level !== 1'b1) begin n_bad++; $display("[TB] FAIL xd_exit_frame: got %b expected 1", new_level); end
        harry_death = 1'b1;
        #1;
        n_cmp++; if (new_level !== 1'b0) begin n_bad++; $display("[TB] FAIL xd_pulse_masked: got %b expected 0", new_level); end
        step(1);
        harry_death = 1'b0;
        keycode = 8'h00;
        n_cmp++; if (state !== 3'd6) begin n_bad++; $display("[TB] FAIL xd_state: got %0d expected 6", state); end
        n_cmp++; if (HarryX !== 10'd623) begin n_bad++; $display("[TB] FAIL xd_x_frozen: got %0d expected 623", HarryX); end
        step(2);
        n_cmp++; if (new_level !== 1'b0) begin n_bad++; $display("[TB] FAIL xd_no_pulse_dead: got %b expected 0", new_level); end
        do_reset();
    endtask

    // Run into a pit: 28 falling frames to the bottom, then 60 dead frames
    // (a repeated death request mid-way must not restart the count).
    task automatic test_pit_death();
        int fall_frames;
        int dead_frames;
        logic [9:0] x_dead;
        keycode = 8'h07;
        step(3);
        n_cmp++; if (HarryX !== 10'd23) begin n_bad++; $display("[TB] FAIL pit_run_x: got %0d expected 23", HarryX); end
        pit_below = 1'b1;
        step(1);
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("[TB] FAIL pit_fall_state: got %0d expected 4", state); end
        n_cmp++; if (HarryY !== 10'd280) begin n_bad++; $display("[TB] FAIL pit_fall_y: got %0d expected 280", HarryY); end
        fall_frames = 0;
        for (int i = 0; i < 60 && state !== 3'd6; i++) begin
            step(1);
            fall_frames++;
        end
        n_cmp++; if (fall_frames !== 28) begin n_bad++; $display("[TB] FAIL pit_fall_frames: got %0d expected 28", fall_frames); end
        n_cmp++; if ((HarryY >= 10'd447) !== 1'b1) begin n_bad++; $display("[TB] FAIL pit_death_y: got %0d expected >=447", HarryY); end
        n_cmp++; if (respawning !== 1'b1) begin n_bad++; $display("[TB] FAIL pit_respawning: got %b expected 1", respawning); end
        x_dead = HarryX;
        dead_frames = 1;
        for (int i = 0; i < 100 && respawning === 1'b1; i++) begin
            harry_death = (dead_frames == 30);
            step(1);
            if (respawning === 1'b1) begin
                dead_frames++;
                if (dead_frames == 40) begin
                    n_cmp++; if (HarryX !== x_dead) begin n_bad++; $display("[TB] FAIL dead_x_frozen: got %0d expected %0d", HarryX, x_dead); end
                end
            end
        end
        harry_death = 1'b0;
        n_cmp++; if (dead_frames !== 60) begin n_bad++; $display("[TB] FAIL dead_frames: got %0d expected 60", dead_frames); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("[TB] FAIL respawn_state: got %0d expected 0", state); end
        n_cmp++; if (HarryX !== 10'd20) begin n_bad++; $display("[TB] FAIL respawn_x: got %0d expected 20", HarryX); end
        n_cmp++; if (HarryY !== 10'd280) begin n_bad++; $display("[TB] FAIL respawn_y: got %0d expected 280", HarryY); end
        pit_below = 1'b0;
        keycode = 8'h00;
        step(1);
    endtask

    // Killed during the rise, then Reset on the tenth dead frame.
    task automatic test_death_reset();
        keycode = 8'h2C;
        step(1);
        keycode = 8'h00;
        step(4);
        n_cmp++; if (HarryY !== 10'd250) begin n_bad++; $display("[TB] FAIL dr_rise_y: got %0d expected 250", HarryY); end
        harry_death = 1'b1;
        step(1);
        harry_death = 1'b0;
        n_cmp++; if (state !== 3'd6) begin n_bad++; $display("[TB] FAIL dr_dead_state: got %0d expected 6", state); end
        n_cmp++; if (airborne !== 1'b0) begin n_bad++; $display("[TB] FAIL dr_airborne: got %b expected 0", airborne); end
        step(9);
        n_cmp++; if (respawning !== 1'b1) begin n_bad++; $display("[TB] FAIL dr_frame10_respawning: got %b expected 1", respawning); end
        n_cmp++; if (HarryY !== 10'd250) begin n_bad++; $display("[TB] FAIL dr_y_frozen: got %0d expected 250", HarryY); end
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("[TB] FAIL dr_reset_state: got %0d expected 0", state); end
        n_cmp++; if (respawning !== 1'b0) begin n_bad++; $display("[TB] FAIL dr_reset_respawning: got %b expected 0", respawning); end
        n_cmp++; if (HarryY !== 10'd280) begin n_bad++; $display("[TB] FAIL dr_reset_y: got %0d expected 280", HarryY); end
    endtask

    // Walk left from X=20 into the left edge.
    task automatic test_left_clamp();
        keycode = 8'h04;
        step(19);
        n_cmp++; if (HarryX !== 10'd1) begin n_bad++; $display("[TB] FAIL clamp_x1: got %0d expected 1", HarryX); end
        step(1);
        n_cmp++; if (HarryX !== 10'd0) begin n_bad++; $display("[TB] FAIL clamp_x0: got %0d expected 0", HarryX); end
        step(5);
        n_cmp++; if (HarryX !== 10'd0) begin n_bad++; $display("[TB] FAIL clamp_hold: got %0d expected 0", HarryX); end
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("[TB] FAIL clamp_state: got %0d expected 1", state); end
        keycode = 8'h00;
        step(1);
    endtask

    // Space held past landing still gives exactly one jump.
    task automatic test_space_held();
        int jumps;
        logic [2:0] prev_state;
        jumps = 0;
        for (int i = 0; i < 90; i++) begin
            keycode = (i < 45) ? 8'h2C : 8'h00;
            prev_state = state;
            step(1);
            if (state === 3'd2 && prev_state !== 3'd2) jumps++;
        end
        n_cmp++; if (jumps !== 1) begin n_bad++; $display("[TB] FAIL held_jump_count: got %0d expected 1", jumps); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("[TB] FAIL held_final_state: got %0d expected 0", state); end
        n_cmp++; if (HarryY !== 10'd280) begin n_bad++; $display("[TB] FAIL held_final_y: got %0d expected 280", HarryY); end
    endtask

    // Scenario sequence.
    initial begin
        Reset = 1'b1; keycode = 8'h00; harry_death = 1'b0; pit_below = 1'b0;
        $display("[TB] harry_jump_ctrl directed test start");
        test_reset();
        test_jump();
        test_edge_exit();
        test_exit_death();
        test_pit_death();
        test_death_reset();
        test_left_clamp();
        test_space_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
